// File: rtl/letter_fifo.sv
// letter_fifo: encodes each new letter press to a 5-bit code and queues it in a FWFT FIFO.
// Define LETTER_FIFO_RECENT_EN to add the 'recent' history of the last 4 accepted codes.
module letter_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [25:0] keys,
    input  logic        key_valid,
    input  logic        clear,
    input  logic        rd_en,
    output logic [4:0]  rd_data,
    output logic        rd_valid,
    output logic [AW:0] count,
    output logic        full,
    output logic        overflow
`ifdef LETTER_FIFO_RECENT_EN
    ,
    output logic [19:0] recent
`endif
);
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [25:0]   keys_q, new_bits, src;
    logic          valid_q, push_req, pop, wr;
    logic [4:0]    code;

    // Prefer the newly added key; fall back to the lowest held key if nothing new.
    always_comb begin
        new_bits = keys & ~keys_q;
        src = |new_bits ? new_bits : keys;
        code = 5'd31;
        for (int i = 25; i >= 0; i--)
            if (src[i]) code = 5'(i);
    end

    assign push_req = key_valid & ~valid_q & |keys;
    assign rd_valid = count != '0;
    assign full     = count == (AW+1)'(DEPTH);
    assign pop      = rd_en & rd_valid;
    assign wr       = push_req & (~full | pop);
    assign rd_data  = rd_valid ? mem[rd_ptr] : 5'd31;

    always_ff @(posedge clk)
        if (wr & ~clear) mem[wr_ptr] <= code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_q   <= '0;
            valid_q  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            keys_q  <= keys;
            valid_q <= key_valid;
            if (clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + (AW+1)'(wr) - (AW+1)'(pop);
                if (push_req & full & ~pop) overflow <= 1'b1;
            end
        end
    end

`ifdef LETTER_FIFO_RECENT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) recent <= '1;
        else if (clear) recent <= '1;
        else if (wr) recent <= {recent[14:0], code};
    end
`endif
endmodule

// File: tb/tb_letter_fifo.sv
// tb_letter_fifo: table-driven vectors plus directed multi-cycle sequences for letter_fifo.
module tb_letter_fifo;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [25:0] keys = '0;
    logic        key_valid = 1'b0, clear = 1'b0, rd_en = 1'b0;
    logic [4:0]  rd_data;
    logic        rd_valid, full, overflow;
    logic [3:0]  count;
`ifdef LETTER_FIFO_RECENT_EN
    logic [19:0] recent;
`endif
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [25:0] keys;
        logic        kv;
        logic        rd;
        logic [4:0]  d;
        logic        v;
        logic [3:0]  c;
    } vec_t;
    vec_t vecs [14];

    always #5 clk = ~clk;

    letter_fifo dut (
        .clk(clk), .rst_n(rst_n), .keys(keys), .key_valid(key_valid), .clear(clear),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .full(full), .overflow(overflow)
`ifdef LETTER_FIFO_RECENT_EN
        , .recent(recent)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic st(input string nm, input int d, input int v, input int c, input int f, input int o);
        chk({nm, ".rd_data"}, 32'(rd_data), 32'(d));
        chk({nm, ".rd_valid"}, 32'(rd_valid), 32'(v));
        chk({nm, ".count"}, 32'(count), 32'(c));
        chk({nm, ".full"}, 32'(full), 32'(f));
        chk({nm, ".overflow"}, 32'(overflow), 32'(o));
    endtask

    task automatic step(input logic [25:0] k, input logic kv, input logic cl, input logic re);
        keys = k; key_valid = kv; clear = cl; rd_en = re;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c);
        step(26'd1 << c, 1'b1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{26'h4, 1'b1, 1'b0, 5'd2,  1'b1, 4'd1};
        vecs[1]  = '{26'h4, 1'b1, 1'b0, 5'd2,  1'b1, 4'd1};
        vecs[2]  = '{26'h4, 1'b1, 1'b0, 5'd2,  1'b1, 4'd1};
        vecs[3]  = '{26'h0, 1'b0, 1'b0, 5'd2,  1'b1, 4'd1};
        vecs[4]  = '{26'h1, 1'b1, 1'b0, 5'd2,  1'b1, 4'd2};
        vecs[5]  = '{26'h1, 1'b0, 1'b0, 5'd2,  1'b1, 4'd2};
        vecs[6]  = '{26'h9, 1'b1, 1'b0, 5'd2,  1'b1, 4'd3};
        vecs[7]  = '{26'h0, 1'b0, 1'b0, 5'd2,  1'b1, 4'd3};
        vecs[8]  = '{26'h0, 1'b1, 1'b0, 5'd2,  1'b1, 4'd3};
        vecs[9]  = '{26'h0, 1'b0, 1'b0, 5'd2,  1'b1, 4'd3};
        vecs[10] = '{26'h0, 1'b0, 1'b1, 5'd0,  1'b1, 4'd2};
        vecs[11] = '{26'h0, 1'b0, 1'b1, 5'd3,  1'b1, 4'd1};
        vecs[12] = '{26'h0, 1'b0, 1'b1, 5'd31, 1'b0, 4'd0};
        vecs[13] = '{26'h0, 1'b0, 1'b1, 5'd31, 1'b0, 4'd0};

        #1;
        st("reset", 31, 0, 0, 0, 0);
`ifdef LETTER_FIFO_RECENT_EN
        chk("reset.recent", 32'(recent), 32'hFFFFF);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].keys, vecs[i].kv, 1'b0, vecs[i].rd);
            chk($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].d));
            chk($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(vecs[i].v));
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].c));
        end

        // overfill by one, then drain in order
        step('0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) push(10 + i);
        st("overfill", 10, 1, 8, 1, 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), 32'(rd_data), 32'(10 + i));
            step('0, 1'b0, 1'b0, 1'b1);
        end
        st("drained", 31, 0, 0, 0, 1);
        step('0, 1'b0, 1'b0, 1'b1);
        st("empty_rd", 31, 0, 0, 0, 1);

        // push and pop together while full
        step('0, 1'b0, 1'b1, 1'b0);
        st("clear", 31, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) push(i);
        st("full8", 0, 1, 8, 1, 0);
        step(26'd1 << 20, 1'b1, 1'b0, 1'b1);
        st("full_pushpop", 1, 1, 8, 1, 0);
        step('0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pp_drain%0d", i), 32'(rd_data), 32'(i < 7 ? i + 1 : 20));
            step('0, 1'b0, 1'b0, 1'b1);
        end
        st("pp_empty", 31, 0, 0, 0, 0);

        // clear wins over a simultaneous push; held strobe does not re-push
        for (int i = 0; i < 5; i++) push(i + 3);
        chk("count5", 32'(count), 32'd5);
        step(26'd1 << 25, 1'b1, 1'b1, 1'b0);
        st("clear_push", 31, 0, 0, 0, 0);
        step(26'd1 << 25, 1'b1, 1'b0, 1'b0);
        st("after_clear", 31, 0, 0, 0, 0);
        step('0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-cycle
        push(7);
        push(8);
        chk("pre_rst", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        st("async_rst", 31, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef LETTER_FIFO_RECENT_EN
        push(10); push(4); push(24); push(18);
        chk("recent4", 32'(recent), 32'({5'd10, 5'd4, 5'd24, 5'd18}));
        push(16);
        chk("recent5", 32'(recent), 32'({5'd4, 5'd24, 5'd18, 5'd16}));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
